// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steps one instruction at a time through fetch, ROM capture, decode
// handshake and PC update for the non-pipelined core.
module fetch_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [31:0]      instr_in,
    input  logic             instr_ready,
    input  logic             br_req,
    input  logic [31:0]      br_immed,
    output logic             pc_lden,
    output logic             pc_sel,
    output logic [31:0]      pc_immed,
    output logic [31:0]      instr_out,
    output logic             instr_valid,
    output logic             busy,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_HOLD,
        S_UPDATE
    } state_t;

    state_t state, state_nxt;

    logic accept;
    logic pc_sel_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    // Handshake only completes while an instruction is actually being presented
    assign accept = (state == S_HOLD) && instr_valid && instr_ready;

    always_comb begin
        state_nxt = state;
        pc_lden   = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:    if (run) state_nxt = S_FETCH;
            S_FETCH:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_HOLD;
            S_HOLD:    if (accept) state_nxt = S_UPDATE;
            S_UPDATE: begin
                pc_lden   = 1'b1;
                state_nxt = run ? S_FETCH : S_IDLE;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc_sel_q    <= 1'b0;
            pc_immed    <= 32'd0;
            instr_out   <= 32'd0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CAPTURE) begin
                instr_out   <= instr_in;
                instr_valid <= 1'b1;
            end
            // Branch choice is frozen at accept and stays put until the PC has loaded
            if (accept) begin
                instr_valid <= 1'b0;
                fetch_count <= sat_inc(fetch_count);
                pc_sel_q    <= br_req;
                pc_immed    <= br_req ? br_immed : 32'd0;
            end
            if (state == S_UPDATE) begin
                pc_sel_q <= 1'b0;
            end
        end
    end

    assign pc_sel = pc_sel_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic checked against an
// instruction-level model of PC progression, handshake accounting and branch selection.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, instr_ready, br_req;
    logic [31:0] instr_in, br_immed;
    logic        pc_lden, pc_sel, instr_valid, busy;
    logic [31:0] pc_immed, instr_out;
    logic [15:0] fetch_count;

    logic        pc_lden2, pc_sel2, instr_valid2, busy2;
    logic [31:0] pc_immed2, instr_out2;
    logic [1:0]  fetch_count2;

    always #5 clk = ~clk;

    fetch_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .instr_in(instr_in), .instr_ready(instr_ready),
        .br_req(br_req), .br_immed(br_immed), .pc_lden(pc_lden), .pc_sel(pc_sel),
        .pc_immed(pc_immed), .instr_out(instr_out), .instr_valid(instr_valid), .busy(busy),
        .fetch_count(fetch_count)
    );

    fetch_sequencer #(.CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .run(run), .instr_in(instr_in), .instr_ready(instr_ready),
        .br_req(br_req), .br_immed(br_immed), .pc_lden(pc_lden2), .pc_sel(pc_sel2),
        .pc_immed(pc_immed2), .instr_out(instr_out2), .instr_valid(instr_valid2), .busy(busy2),
        .fetch_count(fetch_count2)
    );

    // Fetch datapath: PC register and synchronous-read ROM
    logic [31:0] rom [64];
    logic [31:0] pc, rom_q;

    always @(posedge clk) begin
        if (reset) pc <= 32'd0;
        else if (pc_lden) pc <= pc + 32'd4 + (pc_sel ? pc_immed : 32'd0);
        rom_q <= rom[pc[7:2]];
    end
    assign instr_in = rom_q;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction-level reference: which word decode should see and what the PC update must be
    logic [31:0] m_pc;
    int          m_acc;
    bit          m_pend;
    logic        m_sel;
    logic [31:0] m_imm;

    always @(negedge clk) begin
        if (reset) begin
            m_pc   = 32'd0;
            m_acc  = 0;
            m_pend = 1'b0;
        end else begin
            check_eq("fetch_count", 32'(fetch_count), 32'((m_acc > 65535) ? 65535 : m_acc));
            check_eq("fetch_count_w2", 32'(fetch_count2), 32'((m_acc > 3) ? 3 : m_acc));
            check_eq("pc_lden", 32'(pc_lden), 32'(m_pend));
            check_eq("pc_sel", 32'(pc_sel), m_pend ? 32'(m_sel) : 32'd0);
            if (m_pend) check_eq("pc_immed", pc_immed, m_imm);
            m_pend = 1'b0;
            if (instr_valid && instr_ready) begin
                check_eq("instr_word", instr_out, rom[m_pc[7:2]]);
                m_sel  = br_req;
                m_imm  = br_req ? br_immed : 32'd0;
                m_pc   = m_pc + 32'd4 + m_imm;
                m_acc  = m_acc + 1;
                m_pend = 1'b1;
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid();
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) found = 1'b1;
        end
        if (!found) check_eq("wait_valid_timeout", 32'(instr_valid), 32'd1);
    endtask

    task automatic accept_word(input logic br, input logic [31:0] imm, input logic noise);
        wait_valid();
        drive_edge();
        instr_ready = 1'b1;
        br_req      = br;
        br_immed    = imm;
        @(negedge clk);
        drive_edge();
        instr_ready = 1'b0;
        br_req      = noise;
        br_immed    = $urandom;
        @(negedge clk);
        check_eq("upd_lden", 32'(pc_lden), 32'd1);
        check_eq("upd_sel", 32'(pc_sel), 32'(br));
        check_eq("upd_immed", pc_immed, br ? imm : 32'd0);
    endtask

    logic [31:0] held_word;
    logic [15:0] held_count;

    initial begin
        reset = 1'b1; run = 1'b0; instr_ready = 1'b0; br_req = 1'b0; br_immed = 32'd0;
        for (int i = 0; i < 64; i++) rom[i] = {8'(i), 24'($urandom)};
        rom[0] = 32'h2001_0005;
        rom[1] = 32'h2002_0007;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_lden", 32'(pc_lden), 32'd0);
        check_eq("rst_sel", 32'(pc_sel), 32'd0);
        check_eq("rst_immed", pc_immed, 32'd0);
        check_eq("rst_instr", instr_out, 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_count", 32'(fetch_count), 32'd0);

        // Latency and steady-state cadence with decode always ready
        drive_edge();
        reset = 1'b0; run = 1'b1; instr_ready = 1'b1;
        @(negedge clk); check_eq("c0_busy", 32'(busy), 32'd0);
        @(negedge clk); check_eq("c1_busy", 32'(busy), 32'd1);
        check_eq("c1_valid", 32'(instr_valid), 32'd0);
        @(negedge clk); check_eq("c2_valid", 32'(instr_valid), 32'd0);
        @(negedge clk); check_eq("c3_valid", 32'(instr_valid), 32'd1);
        check_eq("c3_instr", instr_out, 32'h2001_0005);
        @(negedge clk); check_eq("c4_lden", 32'(pc_lden), 32'd1);
        check_eq("c4_sel", 32'(pc_sel), 32'd0);
        @(negedge clk); check_eq("c5_valid", 32'(instr_valid), 32'd0);
        @(negedge clk); check_eq("c6_valid", 32'(instr_valid), 32'd0);
        @(negedge clk); check_eq("c7_valid", 32'(instr_valid), 32'd1);
        check_eq("c7_instr", instr_out, 32'h2002_0007);
        drive_edge();
        instr_ready = 1'b0;

        // Backpressure on the PC=8 word, then accept it with a taken branch
        wait_valid();
        held_word  = instr_out;
        held_count = fetch_count;
        check_eq("bp_word", held_word, rom[2]);
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(instr_valid), 32'd1);
            check_eq("bp_instr", instr_out, held_word);
            check_eq("bp_lden", 32'(pc_lden), 32'd0);
            check_eq("bp_count", 32'(fetch_count), 32'(held_count));
        end
        accept_word(1'b1, 32'h10, 1'b0);
        wait_valid();
        check_eq("br_target", instr_out, rom[7]);

        // Branch requests outside the accept cycle must not leak into the update
        accept_word(1'b0, 32'd0, 1'b1);
        accept_word(1'b0, 32'd0, 1'b0);

        // run dropped mid-instruction: finish it, one update, then park
        wait_valid();
        drive_edge();
        run = 1'b0;
        accept_word(1'b0, 32'd0, 1'b0);
        repeat (6) begin
            @(negedge clk);
            check_eq("park_busy", 32'(busy), 32'd0);
            check_eq("park_lden", 32'(pc_lden), 32'd0);
            check_eq("park_valid", 32'(instr_valid), 32'd0);
        end

        // Reset while holding an unaccepted instruction
        drive_edge();
        run = 1'b1;
        wait_valid();
        drive_edge();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("hrst_valid", 32'(instr_valid), 32'd0);
        check_eq("hrst_instr", instr_out, 32'd0);
        check_eq("hrst_busy", 32'(busy), 32'd0);
        check_eq("hrst_lden", 32'(pc_lden), 32'd0);
        check_eq("hrst_sel", 32'(pc_sel), 32'd0);
        check_eq("hrst_immed", pc_immed, 32'd0);
        check_eq("hrst_count", 32'(fetch_count), 32'd0);
        drive_edge();
        reset = 1'b0;
        @(negedge clk);
        check_eq("hrst_idle_lden", 32'(pc_lden), 32'd0);

        // Narrow counter saturation
        for (int k = 0; k < 5; k++) accept_word(1'b0, 32'd0, 1'b0);
        @(negedge clk);
        check_eq("sat_w2", 32'(fetch_count2), 32'd3);
        check_eq("count_w16", 32'(fetch_count), 32'd5);

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            drive_edge();
            reset       = ($urandom_range(0, 599) == 0);
            run         = ($urandom_range(0, 15) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            br_req      = $urandom_range(0, 1);
            br_immed    = $urandom;
        end
        drive_edge();
        reset = 1'b0; run = 1'b0; instr_ready = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("final_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
